// File: rtl/eth_tx_framer_if.sv
// ---------------------------------------------------------------------------
// eth_tx_framer_if
// Byte-wide AXI-Stream bundle used on both sides of the Ethernet TX framer.
//   tdata  : payload byte
//   tvalid : byte is valid
//   tlast  : byte is the last one of a packet
//   tready : sink accepts the byte
// master drives tdata/tvalid/tlast and samples tready; slave is the reverse.
// ---------------------------------------------------------------------------
interface eth_tx_framer_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tlast;
    logic       tready;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/eth_tx_framer.sv
// ---------------------------------------------------------------------------
// eth_tx_framer
// Store-and-forward framer ahead of the Ethernet transmit stage. Payload bytes
// are buffered until the packet's last byte arrives; the packet is then
// committed together with its length and the MAC addresses present at that
// moment. Committed packets are replayed as {header, payload}. Packets longer
// than MAX_PAYLOAD are rewound out of the buffer and counted.
//
// Ports
//   clk          : single clock
//   rst          : asynchronous active-low reset
//   s_axis       : payload input stream (slave)
//   cfg_dst_mac  : destination MAC, captured at packet commit
//   cfg_src_mac  : source MAC, captured at packet commit
//   m_axis       : payload output stream (master)
//   header       : {dst MAC, src MAC, payload length} of the output packet
//   header_valid : header of the current output packet is available
//   header_rd    : one-cycle pulse, downstream consumed the header
//   drop_count   : saturating count of discarded oversize packets
// ---------------------------------------------------------------------------
module eth_tx_framer #(
    parameter int MAX_PAYLOAD = 1500,
    parameter int BUF_DEPTH   = 2048,
    parameter int LEN_DEPTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    eth_tx_framer_if.slave        s_axis,
    input  logic [47:0]           cfg_dst_mac,
    input  logic [47:0]           cfg_src_mac,
    eth_tx_framer_if.master       m_axis,
    output logic [111:0]          header,
    output logic                  header_valid,
    input  logic                  header_rd,
    output logic [15:0]           drop_count
);

    localparam int AW  = $clog2(BUF_DEPTH);
    localparam int PW  = AW + 1;
    localparam int LAW = $clog2(LEN_DEPTH);
    localparam int LCW = LAW + 1;
    localparam int CW  = $clog2(MAX_PAYLOAD + 1);

    typedef enum logic [1:0] {
        IN_IDLE,
        IN_DATA,
        IN_DROP
    } in_state_t;

    typedef enum logic [1:0] {
        OUT_IDLE,
        OUT_PREFETCH,
        OUT_DATA
    } out_state_t;

    // Payload buffer and committed-packet descriptor FIFO
    logic [7:0]     r_buf     [BUF_DEPTH];
    logic [111:0]   r_len_mem [LEN_DEPTH];

    // Input side state
    in_state_t      r_in_state;
    in_state_t      w_in_next;
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_committed_wr;
    logic [CW-1:0]  r_byte_cnt;
    logic [15:0]    r_drop_cnt;
    logic           r_run;

    // Descriptor FIFO pointers
    logic [LAW-1:0] r_len_wr;
    logic [LAW-1:0] r_len_rd;
    logic [LCW-1:0] r_len_cnt;

    // Output side state
    out_state_t     r_out_state;
    out_state_t     w_out_next;
    logic [PW-1:0]  r_rd_ptr;
    logic [15:0]    r_rem;
    logic [111:0]   r_header;
    logic           r_hdr_valid;
    logic [7:0]     r_tdata;

    // Combinational controls
    logic [PW-1:0]  w_occ;
    logic           w_buf_full;
    logic           w_len_full;
    logic           w_len_empty;
    logic           w_s_ready;
    logic           w_wr_en;
    logic           w_commit;
    logic           w_drop;
    logic           w_load;
    logic           w_fetch;
    logic           w_m_valid;
    logic           w_m_hs;
    logic           w_pop;
    logic [AW-1:0]  w_rd_addr;

    // Occupancy counts uncommitted bytes too, so an in-flight packet stalls
    // rather than overwriting committed data that has not been sent yet.
    assign w_occ       = r_wr_ptr - r_rd_ptr;
    assign w_buf_full  = (w_occ == PW'(BUF_DEPTH));
    assign w_len_full  = (r_len_cnt == LCW'(LEN_DEPTH));
    assign w_len_empty = (r_len_cnt == '0);

    // ------------------------------------------------------------------
    // Input FSM: accept, commit or drop
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in_state <= IN_IDLE;
        end else begin
            r_in_state <= w_in_next;
        end
    end

    always_comb begin
        w_in_next = r_in_state;
        w_s_ready = 1'b0;
        w_wr_en   = 1'b0;
        w_commit  = 1'b0;
        w_drop    = 1'b0;
        case (r_in_state)
            IN_IDLE, IN_DATA: begin
                // r_run holds ready low on the first cycle out of reset
                w_s_ready = r_run && !w_buf_full && !w_len_full;
                if (w_s_ready && s_axis.tvalid) begin
                    if (r_byte_cnt == CW'(MAX_PAYLOAD)) begin
                        // This byte would exceed the limit: discard the packet
                        w_drop    = 1'b1;
                        w_in_next = s_axis.tlast ? IN_IDLE : IN_DROP;
                    end else begin
                        w_wr_en = 1'b1;
                        if (s_axis.tlast) begin
                            w_commit  = 1'b1;
                            w_in_next = IN_IDLE;
                        end else begin
                            w_in_next = IN_DATA;
                        end
                    end
                end
            end
            IN_DROP: begin
                w_s_ready = r_run;
                if (s_axis.tvalid && s_axis.tlast) begin
                    w_in_next = IN_IDLE;
                end
            end
            default: begin
                w_in_next = IN_IDLE;
            end
        endcase
    end

    assign s_axis.tready = w_s_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run          <= 1'b0;
            r_wr_ptr       <= '0;
            r_committed_wr <= '0;
            r_byte_cnt     <= '0;
            r_drop_cnt     <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_drop) begin
                // Rewind discards every byte written for this packet
                r_wr_ptr   <= r_committed_wr;
                r_byte_cnt <= '0;
                if (r_drop_cnt != 16'hFFFF) begin
                    r_drop_cnt <= r_drop_cnt + 16'd1;
                end
            end else if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
                if (w_commit) begin
                    r_committed_wr <= r_wr_ptr + PW'(1);
                    r_byte_cnt     <= '0;
                end else begin
                    r_byte_cnt <= r_byte_cnt + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_buf[r_wr_ptr[AW-1:0]] <= s_axis.tdata;
        end
    end

    // ------------------------------------------------------------------
    // Descriptor FIFO: {dst, src, length} per committed packet
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_len_mem[r_len_wr] <= {cfg_dst_mac, cfg_src_mac,
                                    16'(r_byte_cnt) + 16'd1};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_len_wr  <= '0;
            r_len_rd  <= '0;
            r_len_cnt <= '0;
        end else begin
            if (w_commit) begin
                r_len_wr <= r_len_wr + LAW'(1);
            end
            if (w_pop) begin
                r_len_rd <= r_len_rd + LAW'(1);
            end
            case ({w_commit, w_pop})
                2'b10:   r_len_cnt <= r_len_cnt + LCW'(1);
                2'b01:   r_len_cnt <= r_len_cnt - LCW'(1);
                default: r_len_cnt <= r_len_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output FSM: load header, prefetch first byte, stream payload
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_state <= OUT_IDLE;
        end else begin
            r_out_state <= w_out_next;
        end
    end

    always_comb begin
        w_out_next = r_out_state;
        w_load     = 1'b0;
        w_fetch    = 1'b0;
        w_m_valid  = 1'b0;
        w_m_hs     = 1'b0;
        w_pop      = 1'b0;
        w_rd_addr  = r_rd_ptr[AW-1:0];
        case (r_out_state)
            OUT_IDLE: begin
                if (!w_len_empty) begin
                    w_load     = 1'b1;
                    w_out_next = OUT_PREFETCH;
                end
            end
            OUT_PREFETCH: begin
                w_fetch    = 1'b1;
                w_out_next = OUT_DATA;
            end
            OUT_DATA: begin
                w_m_valid = 1'b1;
                if (m_axis.tready) begin
                    // Fetch the byte after the one being handed over so the
                    // output register is refilled without a bubble.
                    w_m_hs    = 1'b1;
                    w_fetch   = 1'b1;
                    w_rd_addr = r_rd_ptr[AW-1:0] + AW'(1);
                    if (r_rem == 16'd1) begin
                        w_pop      = 1'b1;
                        w_out_next = OUT_IDLE;
                    end
                end
            end
            default: begin
                w_out_next = OUT_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr    <= '0;
            r_rem       <= '0;
            r_header    <= '0;
            r_hdr_valid <= 1'b0;
            r_tdata     <= '0;
        end else begin
            if (w_load) begin
                r_header <= r_len_mem[r_len_rd];
                r_rem    <= r_len_mem[r_len_rd][15:0];
            end
            if (w_m_hs) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
                r_rem    <= r_rem - 16'd1;
            end
            if (w_fetch) begin
                r_tdata <= r_buf[w_rd_addr];
            end
            // Valid rises together with the first m_axis beat
            if (r_out_state == OUT_PREFETCH) begin
                r_hdr_valid <= 1'b1;
            end else if (header_rd && r_hdr_valid) begin
                r_hdr_valid <= 1'b0;
            end
        end
    end

    assign m_axis.tvalid = w_m_valid;
    assign m_axis.tlast  = w_m_valid && (r_rem == 16'd1);
    assign m_axis.tdata  = r_tdata;
    assign header        = r_header;
    assign header_valid  = r_hdr_valid;
    assign drop_count    = r_drop_cnt;

endmodule

// File: tb/tb_eth_tx_framer.sv
// ---------------------------------------------------------------------------
// tb_eth_tx_framer
// Directed bench for eth_tx_framer. Each scenario task drives packets and
// compares the captured output stream, headers and counters against values
// computed here from the stimulus.
// ---------------------------------------------------------------------------
module tb_eth_tx_framer;

    logic         clk;
    logic         rst;
    logic [47:0]  cfg_dst;
    logic [47:0]  cfg_src;
    logic [111:0] header;
    logic         header_valid;
    logic         header_rd;
    logic [15:0]  drop_count;

    eth_tx_framer_if s_if();
    eth_tx_framer_if m_if();

    eth_tx_framer dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis       (s_if),
        .cfg_dst_mac  (cfg_dst),
        .cfg_src_mac  (cfg_src),
        .m_axis       (m_if),
        .header       (header),
        .header_valid (header_valid),
        .header_rd    (header_rd),
        .drop_count   (drop_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]   rx_d [$];
    logic         rx_l [$];
    logic [111:0] hdr_q [$];
    logic         hv_q [$];
    int           stall_err = 0;
    bit           in_pkt = 1'b0;
    bit           stalled = 1'b0;
    logic [7:0]   st_d;
    logic         st_l;

    // Output monitor: records every handshake and the header seen on the
    // first beat of each packet; checks stream stability while stalled.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                in_pkt  = 1'b0;
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    if (m_if.tvalid !== 1'b1 || m_if.tdata !== st_d || m_if.tlast !== st_l)
                        stall_err++;
                end
                if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
                    if (!in_pkt) begin
                        hdr_q.push_back(header);
                        hv_q.push_back(header_valid);
                        in_pkt = 1'b1;
                    end
                    rx_d.push_back(m_if.tdata);
                    rx_l.push_back(m_if.tlast);
                    if (m_if.tlast === 1'b1) in_pkt = 1'b0;
                    stalled = 1'b0;
                end else if (m_if.tvalid === 1'b1) begin
                    stalled = 1'b1;
                    st_d    = m_if.tdata;
                    st_l    = m_if.tlast;
                end else begin
                    stalled = 1'b0;
                end
            end
        end
    end

    // Header consumer: pulses header_rd once for each valid header
    initial begin
        header_rd = 1'b0;
        forever begin
            @(negedge clk);
            if (header_valid === 1'b1 && !header_rd) header_rd = 1'b1;
            else header_rd = 1'b0;
        end
    end

    task automatic clear_rx();
        rx_d.delete();
        rx_l.delete();
        hdr_q.delete();
        hv_q.delete();
    endtask

    // Presents one byte; returns one cycle after it was accepted
    task automatic send_byte(input logic [7:0] d, input logic last);
        int guard;
        guard = 0;
        s_if.tdata  = d;
        s_if.tvalid = 1'b1;
        s_if.tlast  = last;
        @(negedge clk);
        while (s_if.tready !== 1'b1 && guard < 5000) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 5000) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: s_axis_tready stayed low, required 1");
        end
        @(posedge clk);
        #1;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic send_pkt(input int len, input logic [7:0] seed);
        @(posedge clk);
        #1;
        for (int i = 0; i < len; i++) begin
            send_byte(seed + 8'(i), (i == len - 1));
        end
    endtask

    task automatic wait_rx(input int n, input int budget, output bit ok);
        int c;
        c = 0;
        while (rx_d.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        ok = (rx_d.size() >= n);
    endtask

    task automatic test_reset();
        rst         = 1'b0;
        s_if.tdata  = '0;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b0;
        cfg_dst     = '0;
        cfg_src     = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (s_if.tready !== 1'b0) begin n_err++; $display("FAIL rst_s_tready got %b need 0", s_if.tready); end
        n_cmp++; if (m_if.tvalid !== 1'b0) begin n_err++; $display("FAIL rst_m_tvalid got %b need 0", m_if.tvalid); end
        n_cmp++; if (m_if.tlast !== 1'b0) begin n_err++; $display("FAIL rst_m_tlast got %b need 0", m_if.tlast); end
        n_cmp++; if (m_if.tdata !== 8'h00) begin n_err++; $display("FAIL rst_m_tdata got %h need 00", m_if.tdata); end
        n_cmp++; if (header_valid !== 1'b0) begin n_err++; $display("FAIL rst_hdr_valid got %b need 0", header_valid); end
        n_cmp++; if (header !== 112'd0) begin n_err++; $display("FAIL rst_header got %h need 0", header); end
        n_cmp++; if (drop_count !== 16'd0) begin n_err++; $display("FAIL rst_drop got %0d need 0", drop_count); end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (s_if.tready !== 1'b1) begin n_err++; $display("FAIL post_rst_s_tready got %b need 1", s_if.tready); end
    endtask

    task automatic test_basic();
        int  n;
        bit  seen;
        bit  ok;
        clear_rx();
        cfg_dst     = 48'h0A0B0C0D0E0F;
        cfg_src     = 48'h112233445566;
        m_if.tready = 1'b1;
        send_pkt(60, 8'h00);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 3) begin
            @(negedge clk);
            n++;
            if (header_valid === 1'b1 && m_if.tvalid === 1'b1) seen = 1'b1;
        end
        n_cmp++; if (!seen) begin n_err++; $display("FAIL basic_latency valid not seen within 3 cycles of commit, need <=3"); end
        wait_rx(60, 200, ok);
        n_cmp++; if (!ok || rx_d.size() != 60) begin n_err++; $display("FAIL basic_count got %0d beats need 60", rx_d.size()); end
        n_cmp++; if (hdr_q.size() != 1 || hdr_q[0] !== 112'h0A0B0C0D0E0F_112233445566_003C)
            begin n_err++; $display("FAIL basic_header got %h need 0a0b0c0d0e0f112233445566003c", (hdr_q.size() > 0) ? hdr_q[0] : 112'd0); end
        n_cmp++; if (hv_q.size() != 1 || hv_q[0] !== 1'b1) begin n_err++; $display("FAIL basic_hv_first_beat header_valid not high at first beat, need 1"); end
        if (rx_d.size() == 60) begin
            for (int i = 0; i < 60; i++) begin
                n_cmp++;
                if (rx_d[i] !== 8'(i) || rx_l[i] !== (i == 59)) begin
                    n_err++;
                    $display("FAIL basic_beat[%0d] got d=%h l=%b need d=%h l=%b", i, rx_d[i], rx_l[i], 8'(i), (i == 59));
                end
            end
        end
        n_cmp++; if (drop_count !== 16'd0) begin n_err++; $display("FAIL basic_drop got %0d need 0", drop_count); end
        repeat (5) @(negedge clk);
        n_cmp++; if (header_valid !== 1'b0) begin n_err++; $display("FAIL basic_hdr_rd header_valid got %b need 0", header_valid); end
    endtask

    task automatic test_drop();
        bit ok;
        clear_rx();
        m_if.tready = 1'b1;
        send_pkt(1501, 8'h10);
        repeat (10) @(negedge clk);
        n_cmp++; if (drop_count !== 16'd1) begin n_err++; $display("FAIL drop_cnt1 got %0d need 1", drop_count); end
        n_cmp++; if (rx_d.size() != 0) begin n_err++; $display("FAIL drop_leak1 got %0d beats need 0", rx_d.size()); end
        send_pkt(1503, 8'h20);
        repeat (10) @(negedge clk);
        n_cmp++; if (drop_count !== 16'd2) begin n_err++; $display("FAIL drop_cnt2 got %0d need 2", drop_count); end
        n_cmp++; if (rx_d.size() != 0) begin n_err++; $display("FAIL drop_leak2 got %0d beats need 0", rx_d.size()); end
        cfg_dst = 48'hFFEEDDCCBBAA;
        cfg_src = 48'h001122334455;
        send_pkt(10, 8'h40);
        wait_rx(10, 100, ok);
        repeat (5) @(negedge clk);
        n_cmp++; if (!ok || rx_d.size() != 10) begin n_err++; $display("FAIL drop_next_count got %0d need 10", rx_d.size()); end
        n_cmp++; if (hdr_q.size() != 1 || hdr_q[0] !== 112'hFFEEDDCCBBAA_001122334455_000A)
            begin n_err++; $display("FAIL drop_next_header got %h need ffeeddccbbaa001122334455000a", (hdr_q.size() > 0) ? hdr_q[0] : 112'd0); end
        if (rx_d.size() == 10) begin
            for (int i = 0; i < 10; i++) begin
                n_cmp++;
                if (rx_d[i] !== 8'h40 + 8'(i) || rx_l[i] !== (i == 9)) begin
                    n_err++;
                    $display("FAIL drop_next_beat[%0d] got d=%h l=%b need d=%h l=%b", i, rx_d[i], rx_l[i], 8'h40 + 8'(i), (i == 9));
                end
            end
        end
        n_cmp++; if (dut.w_occ !== '0) begin n_err++; $display("FAIL drop_occupancy got %0d need 0", dut.w_occ); end
    endtask

    task automatic test_back_to_back();
        bit           ok;
        logic [111:0] exp_h;
        logic [7:0]   exp_d;
        clear_rx();
        m_if.tready = 1'b0;
        for (int p = 0; p < 8; p++) begin
            cfg_dst = 48'h020000000000 | 48'(p);
            cfg_src = 48'h0600000000A0 + 48'(p);
            send_pkt(100, 8'(p * 16));
        end
        repeat (3) @(negedge clk);
        n_cmp++; if (s_if.tready !== 1'b0) begin n_err++; $display("FAIL b2b_len_full s_tready got %b need 0", s_if.tready); end
        n_cmp++; if (rx_d.size() != 0) begin n_err++; $display("FAIL b2b_held got %0d beats need 0", rx_d.size()); end
        @(posedge clk);
        #1;
        m_if.tready = 1'b1;
        wait_rx(800, 3000, ok);
        repeat (5) @(negedge clk);
        n_cmp++; if (!ok || rx_d.size() != 800) begin n_err++; $display("FAIL b2b_count got %0d need 800", rx_d.size()); end
        n_cmp++; if (hdr_q.size() != 8) begin n_err++; $display("FAIL b2b_hdr_count got %0d need 8", hdr_q.size()); end
        if (hdr_q.size() == 8 && rx_d.size() == 800) begin
            for (int p = 0; p < 8; p++) begin
                exp_h = {48'h020000000000 | 48'(p), 48'h0600000000A0 + 48'(p), 16'd100};
                n_cmp++;
                if (hdr_q[p] !== exp_h) begin
                    n_err++;
                    $display("FAIL b2b_header[%0d] got %h need %h", p, hdr_q[p], exp_h);
                end
                for (int i = 0; i < 100; i++) begin
                    exp_d = 8'(p * 16) + 8'(i);
                    n_cmp++;
                    if (rx_d[p * 100 + i] !== exp_d || rx_l[p * 100 + i] !== (i == 99)) begin
                        n_err++;
                        $display("FAIL b2b_beat[%0d][%0d] got d=%h l=%b need d=%h l=%b", p, i,
                                 rx_d[p * 100 + i], rx_l[p * 100 + i], exp_d, (i == 99));
                    end
                end
            end
        end
        n_cmp++; if (s_if.tready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_back got %b need 1", s_if.tready); end
    endtask

    task automatic test_stall();
        clear_rx();
        stall_err   = 0;
        m_if.tready = 1'b0;
        cfg_dst     = 48'h123456789ABC;
        cfg_src     = 48'hCBA987654321;
        fork
            send_pkt(46, 8'h80);
            begin
                int c;
                c = 0;
                while (rx_d.size() < 46 && c < 2000) begin
                    @(posedge clk);
                    #1;
                    m_if.tready = 1'($urandom_range(0, 1));
                    c++;
                end
            end
        join
        @(posedge clk);
        #1;
        m_if.tready = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++; if (rx_d.size() != 46) begin n_err++; $display("FAIL stall_count got %0d need 46", rx_d.size()); end
        n_cmp++; if (hdr_q.size() != 1 || hdr_q[0] !== 112'h123456789ABC_CBA987654321_002E)
            begin n_err++; $display("FAIL stall_header got %h need 123456789abccba987654321002e", (hdr_q.size() > 0) ? hdr_q[0] : 112'd0); end
        if (rx_d.size() == 46) begin
            for (int i = 0; i < 46; i++) begin
                n_cmp++;
                if (rx_d[i] !== 8'h80 + 8'(i) || rx_l[i] !== (i == 45)) begin
                    n_err++;
                    $display("FAIL stall_beat[%0d] got d=%h l=%b need d=%h l=%b", i, rx_d[i], rx_l[i], 8'h80 + 8'(i), (i == 45));
                end
            end
        end
        n_cmp++; if (stall_err != 0) begin n_err++; $display("FAIL stall_stable got %0d unstable cycles need 0", stall_err); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_rx();
        m_if.tready = 1'b1;
        cfg_dst     = 48'h0000000000AA;
        cfg_src     = 48'h0000000000BB;
        send_pkt(64, 8'hC0);
        wait_rx(20, 200, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL rmid_reach got %0d beats need 20", rx_d.size()); end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if (m_if.tvalid !== 1'b0) begin n_err++; $display("FAIL rmid_tvalid got %b need 0", m_if.tvalid); end
        n_cmp++; if (m_if.tlast !== 1'b0) begin n_err++; $display("FAIL rmid_tlast got %b need 0", m_if.tlast); end
        n_cmp++; if (m_if.tdata !== 8'h00) begin n_err++; $display("FAIL rmid_tdata got %h need 00", m_if.tdata); end
        n_cmp++; if (header_valid !== 1'b0) begin n_err++; $display("FAIL rmid_hdr_valid got %b need 0", header_valid); end
        n_cmp++; if (header !== 112'd0) begin n_err++; $display("FAIL rmid_header got %h need 0", header); end
        n_cmp++; if (drop_count !== 16'd0) begin n_err++; $display("FAIL rmid_drop got %0d need 0", drop_count); end
        n_cmp++; if (s_if.tready !== 1'b0) begin n_err++; $display("FAIL rmid_s_tready got %b need 0", s_if.tready); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        clear_rx();
        cfg_dst = 48'hA1A2A3A4A5A6;
        cfg_src = 48'hB1B2B3B4B5B6;
        send_pkt(5, 8'h55);
        wait_rx(5, 100, ok);
        repeat (10) @(negedge clk);
        n_cmp++; if (!ok || rx_d.size() != 5) begin n_err++; $display("FAIL rmid_new_count got %0d need 5", rx_d.size()); end
        n_cmp++; if (hdr_q.size() != 1 || hdr_q[0] !== 112'hA1A2A3A4A5A6_B1B2B3B4B5B6_0005)
            begin n_err++; $display("FAIL rmid_new_header got %h need a1a2a3a4a5a6b1b2b3b4b5b60005", (hdr_q.size() > 0) ? hdr_q[0] : 112'd0); end
        if (rx_d.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                n_cmp++;
                if (rx_d[i] !== 8'h55 + 8'(i) || rx_l[i] !== (i == 4)) begin
                    n_err++;
                    $display("FAIL rmid_new_beat[%0d] got d=%h l=%b need d=%h l=%b", i, rx_d[i], rx_l[i], 8'h55 + 8'(i), (i == 4));
                end
            end
        end
    endtask

    task automatic test_single();
        bit ok;
        clear_rx();
        m_if.tready = 1'b1;
        cfg_dst     = 48'h0A0B0C0D0E0F;
        cfg_src     = 48'h112233445566;
        send_pkt(1, 8'hA5);
        wait_rx(1, 50, ok);
        repeat (5) @(negedge clk);
        n_cmp++; if (!ok || rx_d.size() != 1) begin n_err++; $display("FAIL single_count got %0d need 1", rx_d.size()); end
        n_cmp++; if (rx_d.size() != 1 || rx_d[0] !== 8'hA5 || rx_l[0] !== 1'b1)
            begin n_err++; $display("FAIL single_beat got d=%h l=%b need d=a5 l=1", (rx_d.size() > 0) ? rx_d[0] : 8'h00, (rx_l.size() > 0) ? rx_l[0] : 1'b0); end
        n_cmp++; if (hdr_q.size() != 1 || hdr_q[0] !== 112'h0A0B0C0D0E0F_112233445566_0001)
            begin n_err++; $display("FAIL single_header got %h need 0a0b0c0d0e0f1122334455660001", (hdr_q.size() > 0) ? hdr_q[0] : 112'd0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_drop();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_single();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
